extrema_detect: RTL and testbench
=================================

# extrema_detect

Streaming local-extremum detector for the EMD envelope path, directly upstream of the extremum store. It tracks one signed 16-bit sample stream, confirms each local maximum (or minimum, per parameter), and emits a one-cycle `Trg` pulse with the extremum magnitude on `Mout` and its position code on `Pout`. `Pout` carries the extremum sample index plus 2, so the store's `Pin-2` recovers the true index.

## Interface
- `EXT_TYPE`, default 1: 1 = detect maxima, 0 = detect minima.
- `HYST`, default 4: confirmation threshold, only used when `EXTR_HYST_EN` is defined; legal range 1..32767.
- `CLK` input 1: single clock; all logic on rising edge.
- `RSTn` input 1: reset, synchronous, active-low.
- `Din` input 16: signed sample.
- `Din_vld` input 1: `Din` accepted on a rising `CLK` edge when high.
- `Trg` output 1: one-cycle pulse; an extremum has been confirmed.
- `Mout` output 16: signed extremum magnitude; valid from the `Trg` cycle, held until the next `Trg`.
- `Pout` output 16: extremum position code, (index + 2) mod 65536; same validity as `Mout`.

## Operation
- Sample index counter `n`, 16 bits: 0 for the first accepted sample after reset; +1 per accepted sample; wraps 65535→0.
- Minima mode: internally compare `-Din` in 17-bit arithmetic; `Mout` always reports the original `Din` value.
- Threshold `T`: equals 1 without `EXTR_HYST_EN`, so comparisons reduce to strict < / >; equals `HYST` with it. All differences are computed in 17-bit signed arithmetic, with no saturation.
- FSM state names: `INIT`, `SEEK_VALLEY`, `SEEK_PEAK`. Registers: candidate value `C`, candidate index `Cp`, valley value `V`.
- `INIT`: on the first accepted sample x, set `V`=x and go to `SEEK_VALLEY`. A stream endpoint is never reported.
- `SEEK_VALLEY`:
  - x < `V`: set `V`=x.
  - x ≥ `V`+T: set `C`=x, `Cp`=n, go to `SEEK_PEAK`.
  - Otherwise: no change.
- `SEEK_PEAK`:
  - x > `C`: set `C`=x, `Cp`=n. Equality does not update, so the first sample of a plateau is kept.
  - x ≤ `C`−T: confirm. Set `Mout`=`C`, `Pout`=`Cp`+2, pulse `Trg`, set `V`=x, go to `SEEK_VALLEY`.
  - Otherwise: no change.
- `Din_vld` low: no state, counter, or output change; `Trg` stays 0.

## Timing
- Reset (`RSTn`=0 at a rising edge): `Trg`=0, `Mout`=0, `Pout`=0, `n`=0, `C`/`Cp`/`V`=0, state `INIT`.
- Reset dominates `Din_vld`. Reset mid-run discards any unconfirmed candidate; no `Trg` is produced for it.
- Latency: `Trg` is high in the cycle after the edge that accepts the confirming sample. `Mout`/`Pout` update on that same edge.
- `Trg` is high for exactly one cycle. Two pulses are separated by at least 2 accepted samples, so `Trg` is low for at least 1 cycle between pulses. The downstream store uses the rising edge of `Trg`.
- No back-pressure. The block accepts one sample per cycle continuously.

## Configuration
- `EXTR_HYST_EN` defined: T = `HYST`. Excursions smaller than `HYST` neither confirm a peak nor re-arm from a valley, which suppresses noise ripple.
- Not defined: T = 1, giving plain strict-slope-change detection. `HYST` is ignored, and no hysteresis logic is synthesized.

## Test plan
- Plateau, max mode, no macro: `Din` = 0,5,9,9,4 on consecutive cycles → one `Trg`, one cycle after sample 4 is accepted; `Mout`=9, `Pout`=4 (plateau start index 2 + 2).
- Min mode, no macro: 10,3,3,7,2,8 → `Trg` after sample 3 with `Mout`=3, `Pout`=3; second `Trg` after sample 5 with `Mout`=2, `Pout`=6.
- Hysteresis, `EXTR_HYST_EN`, `HYST`=4, max mode: 0,10,8,11,6 → no `Trg` at 8; single `Trg` after 6 with `Mout`=11, `Pout`=5. Same stimulus without the macro → `Trg` after 8 with `Mout`=10, `Pout`=3.
- Valid gaps: 0,5,9,4 with `Din_vld` low for 3 cycles between each pair → same result as contiguous input: `Mout`=9, `Pout`=4, and no `Trg` during the gaps.
- Reset mid-run: 0,5 accepted, `RSTn` low for 1 cycle, then 3,1 → no `Trg`; the next extremum index restarts from 0.
- Counter wrap: 65534 zeros, then 7 (index 65534), then 1 → `Trg` with `Mout`=7, `Pout`=0.

Source files
------------

// File: rtl/extrema_detect.sv
// Streaming local-extremum detector: confirms peaks (EXT_TYPE=1) or valleys (EXT_TYPE=0)
// of a signed 16-bit stream. Optional hysteresis threshold enabled by macro EXTR_HYST_EN.
module extrema_detect #(
    parameter int EXT_TYPE = 1,
    parameter int HYST     = 4
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [15:0] Din,
    input  logic        Din_vld,
    output logic        Trg,
    output logic [15:0] Mout,
    output logic [15:0] Pout
);

    typedef enum logic [1:0] {
        INIT        = 2'd0,
        SEEK_VALLEY = 2'd1,
        SEEK_PEAK   = 2'd2
    } state_t;

`ifdef EXTR_HYST_EN
    localparam logic signed [16:0] THRESH = 17'(HYST);
`else
    localparam logic signed [16:0] THRESH = 17'sd1;
`endif

    // A bad HYST override is rejected even when hysteresis is compiled out.
    if (HYST < 1 || HYST > 32767) begin : g_bad_hyst
        $error("extrema_detect: HYST must be in 1..32767");
    end

    state_t             state_q, state_d;
    logic signed [16:0] c_q, c_d;
    logic signed [16:0] v_q, v_d;
    logic [15:0]        cp_q, cp_d;
    logic [15:0]        cm_q, cm_d;
    logic [15:0]        n_q, n_d;
    logic [15:0]        mout_q, mout_d;
    logic [15:0]        pout_q, pout_d;
    logic               trg_q, trg_d;

    logic signed [16:0] din_sx;
    logic signed [16:0] x;
    logic signed [16:0] rise_v;
    logic signed [16:0] drop_c;

    // Minima are found as maxima of the negated stream; 17 bits make -(-32768) exact,
    // and every difference below stays in range without saturation.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        c_d     = c_q;
        v_d     = v_q;
        cp_d    = cp_q;
        cm_d    = cm_q;
        n_d     = n_q;
        mout_d  = mout_q;
        pout_d  = pout_q;
        trg_d   = 1'b0;

        din_sx = {Din[15], Din};
        x      = (EXT_TYPE != 0) ? din_sx : -din_sx;
        rise_v = x - v_q;
        drop_c = c_q - x;

        if (Din_vld) begin
            n_d = n_q + 16'd1;
            unique case (state_q)
                INIT: begin
                    v_d     = x;
                    state_d = SEEK_VALLEY;
                end
                SEEK_VALLEY: begin
                    if (rise_v < 0) begin
                        v_d = x;
                    end else if (rise_v >= THRESH) begin
                        c_d     = x;
                        cm_d    = Din;
                        cp_d    = n_q;
                        state_d = SEEK_PEAK;
                    end
                end
                SEEK_PEAK: begin
                    // Strict > keeps the first sample of a plateau as the candidate.
                    if (x > c_q) begin
                        c_d  = x;
                        cm_d = Din;
                        cp_d = n_q;
                    end else if (drop_c >= THRESH) begin
                        mout_d  = cm_q;
                        pout_d  = cp_q + 16'd2;
                        trg_d   = 1'b1;
                        v_d     = x;
                        state_d = SEEK_VALLEY;
                    end
                end
                default: state_d = INIT;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!RSTn) begin
            state_q <= INIT;
            c_q     <= '0;
            v_q     <= '0;
            cp_q    <= '0;
            cm_q    <= '0;
            n_q     <= '0;
            mout_q  <= '0;
            pout_q  <= '0;
            trg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            v_q     <= v_d;
            cp_q    <= cp_d;
            cm_q    <= cm_d;
            n_q     <= n_d;
            mout_q  <= mout_d;
            pout_q  <= pout_d;
            trg_q   <= trg_d;
        end
    end

    assign Trg  = trg_q;
    assign Mout = mout_q;
    assign Pout = pout_q;

endmodule

// File: tb/tb_extrema_detect.sv
// Bench for extrema_detect: directed vector table, counter-wrap sequence and
// randomized stimulus against an integer reference model (max and min instances).
module tb_extrema_detect;

`ifdef EXTR_HYST_EN
    localparam int T       = 4;
    localparam bit HYST_ON = 1'b1;
`else
    localparam int T       = 1;
    localparam bit HYST_ON = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        Din_vld = 1'b0;
    logic [15:0] Din = '0;
    logic        trg_mx, trg_mn;
    logic [15:0] mout_mx, mout_mn, pout_mx, pout_mn;

    always #5 CLK = ~CLK;

    extrema_detect #(.EXT_TYPE(1), .HYST(4)) u_max (
        .CLK(CLK), .RSTn(RSTn), .Din(Din), .Din_vld(Din_vld),
        .Trg(trg_mx), .Mout(mout_mx), .Pout(pout_mx)
    );

    extrema_detect #(.EXT_TYPE(0), .HYST(4)) u_min (
        .CLK(CLK), .RSTn(RSTn), .Din(Din), .Din_vld(Din_vld),
        .Trg(trg_mn), .Mout(mout_mn), .Pout(pout_mn)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: index 1 = maxima, 0 = minima; phase 0 = no sample yet,
    // 1 = looking for a rise off the valley, 2 = tracking a candidate.
    int          md_phase[2];
    int          md_v[2];
    int          md_c[2];
    int          md_cp[2];
    int          md_n;
    bit          ex_trg[2];
    logic [15:0] ex_m[2];
    logic [15:0] ex_p[2];

    task automatic model_step(input bit rst, input bit vld, input logic [15:0] d);
        int xs;
        int x;
        xs = int'($signed(d));
        for (int k = 0; k < 2; k++) ex_trg[k] = 1'b0;
        if (!rst) begin
            md_n = 0;
            for (int k = 0; k < 2; k++) begin
                md_phase[k] = 0; md_v[k] = 0; md_c[k] = 0; md_cp[k] = 0;
                ex_m[k] = '0; ex_p[k] = '0;
            end
        end else if (vld) begin
            for (int k = 0; k < 2; k++) begin
                x = (k == 1) ? xs : -xs;
                if (md_phase[k] == 0) begin
                    md_v[k] = x;
                    md_phase[k] = 1;
                end else if (md_phase[k] == 1) begin
                    if (x < md_v[k]) md_v[k] = x;
                    else if (x >= md_v[k] + T) begin
                        md_c[k] = x; md_cp[k] = md_n; md_phase[k] = 2;
                    end
                end else begin
                    if (x > md_c[k]) begin
                        md_c[k] = x; md_cp[k] = md_n;
                    end else if (x <= md_c[k] - T) begin
                        ex_m[k]   = 16'((k == 1) ? md_c[k] : -md_c[k]);
                        ex_p[k]   = 16'((md_cp[k] + 2) % 65536);
                        ex_trg[k] = 1'b1;
                        md_v[k]   = x;
                        md_phase[k] = 1;
                    end
                end
            end
            md_n = (md_n + 1) % 65536;
        end
    endtask

    task automatic apply(input bit rst, input bit vld, input logic [15:0] d);
        RSTn    = rst;
        Din_vld = vld;
        Din     = d;
        @(posedge CLK);
        model_step(rst, vld, d);
        #1;
    endtask

    typedef struct {
        bit          sel;   // 1 = check max instance, 0 = min instance
        bit          rst;
        bit          vld;
        logic [15:0] din;
        bit          trg;
        logic [15:0] m;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit sel, input bit rst, input bit vld, input logic [15:0] din,
                       input bit trg, input logic [15:0] m, input logic [15:0] p);
        vec_t v;
        v.sel = sel; v.rst = rst; v.vld = vld; v.din = din;
        v.trg = trg; v.m = m; v.p = p;
        vecs.push_back(v);
    endtask

    initial begin
        bit quiet_bad;
        int din_i;
        bit rst_r, vld_r;

        // Plateau, max mode: first plateau sample is reported.
        add(1, 0, 1, 16'h1234, 0, 0, 0);
        add(1, 1, 1, 16'd0, 0, 0, 0);
        add(1, 1, 1, 16'd5, 0, 0, 0);
        add(1, 1, 1, 16'd9, 0, 0, 0);
        add(1, 1, 1, 16'd9, 0, 0, 0);
        add(1, 1, 1, 16'd4, 1, 9, 4);
        add(1, 1, 0, 16'd4, 0, 9, 4);
        // Minima mode.
        add(0, 0, 1, 16'd0, 0, 0, 0);
        add(0, 1, 1, 16'd10, 0, 0, 0);
        add(0, 1, 1, 16'd3, 0, 0, 0);
        add(0, 1, 1, 16'd3, 0, 0, 0);
        add(0, 1, 1, 16'd7, 1, 3, 3);
        add(0, 1, 1, 16'd2, 0, 3, 3);
        add(0, 1, 1, 16'd8, 1, 2, 6);
        add(0, 1, 0, 16'd8, 0, 2, 6);
        // Small dip at 8 is filtered only with hysteresis.
        add(1, 0, 1, 16'd0, 0, 0, 0);
        add(1, 1, 1, 16'd0, 0, 0, 0);
        add(1, 1, 1, 16'd10, 0, 0, 0);
        add(1, 1, 1, 16'd8, !HYST_ON, HYST_ON ? 16'd0 : 16'd10, HYST_ON ? 16'd0 : 16'd3);
        add(1, 1, 1, 16'd11, 0, HYST_ON ? 16'd0 : 16'd10, HYST_ON ? 16'd0 : 16'd3);
        add(1, 1, 1, 16'd6, 1, 11, 5);
        add(1, 1, 0, 16'd6, 0, 11, 5);
        // Valid gaps carry garbage that must be ignored.
        add(1, 0, 1, 16'd0, 0, 0, 0);
        add(1, 1, 1, 16'd0, 0, 0, 0);
        for (int g = 0; g < 3; g++) add(1, 1, 0, 16'h7fff, 0, 0, 0);
        add(1, 1, 1, 16'd5, 0, 0, 0);
        for (int g = 0; g < 3; g++) add(1, 1, 0, 16'h8000, 0, 0, 0);
        add(1, 1, 1, 16'd9, 0, 0, 0);
        for (int g = 0; g < 3; g++) add(1, 1, 0, 16'h7fff, 0, 0, 0);
        add(1, 1, 1, 16'd4, 1, 9, 4);
        add(1, 1, 0, 16'd4, 0, 9, 4);
        // Reset mid-run drops the candidate and restarts the index.
        add(1, 0, 1, 16'd0, 0, 0, 0);
        add(1, 1, 1, 16'd0, 0, 0, 0);
        add(1, 1, 1, 16'd5, 0, 0, 0);
        add(1, 0, 1, 16'd50, 0, 0, 0);
        add(1, 1, 1, 16'd3, 0, 0, 0);
        add(1, 1, 1, 16'd1, 0, 0, 0);
        add(1, 1, 1, 16'd6, 0, 0, 0);
        add(1, 1, 1, 16'd0, 1, 6, 4);
        add(1, 1, 0, 16'd0, 0, 6, 4);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].vld, vecs[i].din);
            if (vecs[i].sel) begin
                check($sformatf("vec%0d.max.trg", i), trg_mx, vecs[i].trg);
                check($sformatf("vec%0d.max.mout", i), mout_mx, vecs[i].m);
                check($sformatf("vec%0d.max.pout", i), pout_mx, vecs[i].p);
            end else begin
                check($sformatf("vec%0d.min.trg", i), trg_mn, vecs[i].trg);
                check($sformatf("vec%0d.min.mout", i), mout_mn, vecs[i].m);
                check($sformatf("vec%0d.min.pout", i), pout_mn, vecs[i].p);
            end
        end

        // Counter wrap: peak at index 65534 reports position code 0.
        apply(0, 1, 16'd0);
        quiet_bad = 1'b0;
        for (int i = 0; i < 65534; i++) begin
            apply(1, 1, 16'd0);
            if (trg_mx !== 1'b0) quiet_bad = 1'b1;
        end
        check("wrap.quiet", quiet_bad, 1'b0);
        apply(1, 1, 16'd7);
        check("wrap.cand.trg", trg_mx, 1'b0);
        apply(1, 1, 16'd1);
        check("wrap.trg", trg_mx, 1'b1);
        check("wrap.mout", mout_mx, 16'd7);
        check("wrap.pout", pout_mx, 16'd0);

        // Randomized run against the model, both polarities.
        apply(0, 1, 16'd0);
        for (int i = 0; i < 3000; i++) begin
            rst_r = ($urandom_range(0, 199) != 0);
            vld_r = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) din_i = int'($urandom_range(0, 65535));
            else din_i = int'($urandom_range(0, 40)) - 20;
            apply(rst_r, vld_r, 16'(din_i));
            check($sformatf("rnd%0d.max.trg", i), trg_mx, ex_trg[1]);
            check($sformatf("rnd%0d.max.mout", i), mout_mx, ex_m[1]);
            check($sformatf("rnd%0d.max.pout", i), pout_mx, ex_p[1]);
            check($sformatf("rnd%0d.min.trg", i), trg_mn, ex_trg[0]);
            check($sformatf("rnd%0d.min.mout", i), mout_mn, ex_m[0]);
            check($sformatf("rnd%0d.min.pout", i), pout_mn, ex_p[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
